// File: rtl/axis_adc_acq_sequencer.sv
// ADC acquisition sequencer: trigger, settle, then gate N beats onto AXIS.
// Overflowing samples are dropped (source cannot stall) and counted.
module axis_adc_acq_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 24,
  parameter int DELAY_WIDTH      = 16
) (
  input  logic                        aclk,
  input  logic                        reset,
  input  logic                        trigger,
  input  logic [1:0]                  cfg_mode,
  input  logic [DELAY_WIDTH-1:0]      cfg_delay,
  input  logic [CNT_WIDTH-1:0]        cfg_samples,
  output logic [1:0]                  adc_channel_switch,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        busy,
  output logic                        overrun,
  output logic [CNT_WIDTH-1:0]        drop_count
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    ACQ,
    DRAIN
  } state_t;

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DELAY_WIDTH-1:0] DLY_ONE = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]             SW_OFF  = 2'b11;

  state_t                        state_q, state_d;
  logic [1:0]                    sw_q, sw_d;
  logic [DELAY_WIDTH-1:0]        dly_q, dly_d;
  logic [CNT_WIDTH-1:0]          num_q, num_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]          drop_q, drop_d;
  logic [AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                          tvalid_q, tvalid_d;
  logic                          tlast_q, tlast_d;
  logic                          ovr_q, ovr_d;
  logic                          pend_q, pend_d;
  logic                          xfer;
  logic                          is_last;

  assign xfer    = tvalid_q & m_axis_tready;
  assign is_last = (cnt_q + CNT_ONE) == num_q;

  always_comb begin
    state_d  = state_q;
    sw_d     = sw_q;
    dly_d    = dly_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    ovr_d    = ovr_q;
    pend_d   = pend_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q & ~m_axis_tready;

    unique case (state_q)
      IDLE: begin
        if (trigger && (cfg_samples != '0)) begin
          state_d = DELAY;
          sw_d    = cfg_mode;
          dly_d   = cfg_delay;
          num_d   = cfg_samples;
          cnt_d   = '0;
          drop_d  = '0;
          ovr_d   = 1'b0;
          pend_d  = 1'b0;
        end
      end
      DELAY: begin
        if (dly_q == '0) begin
          state_d = ACQ;
        end else begin
          dly_d = dly_q - DLY_ONE;
        end
      end
      ACQ: begin
        if (s_axis_tvalid) begin
          cnt_d = cnt_q + CNT_ONE;
          if (!tvalid_q || xfer) begin
            tvalid_d = 1'b1;
            tdata_d  = s_axis_tdata;
            tlast_d  = is_last;
          end else begin
            // Held beat must stay stable, so the new sample is lost
            ovr_d = 1'b1;
            if (drop_q != '1) begin
              drop_d = drop_q + CNT_ONE;
            end
            if (is_last) begin
              pend_d = 1'b1;
            end
          end
          if (is_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pend_q) begin
          // Final sample was lost: close the frame with a zero tlast beat
          if (!tvalid_q) begin
            tvalid_d = 1'b1;
            tdata_d  = '0;
            tlast_d  = 1'b1;
            pend_d   = 1'b0;
          end
        end else if (xfer && tlast_q) begin
          state_d = IDLE;
          sw_d    = SW_OFF;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q  <= IDLE;
      sw_q     <= SW_OFF;
      dly_q    <= '0;
      num_q    <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      ovr_q    <= 1'b0;
      pend_q   <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sw_q     <= sw_d;
      dly_q    <= dly_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      ovr_q    <= ovr_d;
      pend_q   <= pend_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign adc_channel_switch = sw_q;
  assign m_axis_tdata       = tdata_q;
  assign m_axis_tvalid      = tvalid_q;
  assign m_axis_tlast       = tlast_q;
  assign busy               = (state_q != IDLE);
  assign overrun            = ovr_q;
  assign drop_count         = drop_q;

endmodule

// File: tb/tb_axis_adc_acq_sequencer.sv
// Bench for axis_adc_acq_sequencer: frame-level model plus directed frames.
// Inputs change #1 after posedge; model and compare run on negedge.
module tb_axis_adc_acq_sequencer;

  localparam int AW = 32;
  localparam int CW = 24;
  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          reset;
  logic          trigger;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_delay;
  logic [CW-1:0] cfg_samples;
  logic [1:0]    adc_channel_switch;
  logic [AW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic [AW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic          overrun;
  logic [CW-1:0] drop_count;

  axis_adc_acq_sequencer #(
    .AXIS_TDATA_WIDTH(AW),
    .CNT_WIDTH(CW),
    .DELAY_WIDTH(DW)
  ) dut (
    .aclk(aclk),
    .reset(reset),
    .trigger(trigger),
    .cfg_mode(cfg_mode),
    .cfg_delay(cfg_delay),
    .cfg_samples(cfg_samples),
    .adc_channel_switch(adc_channel_switch),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy),
    .overrun(overrun),
    .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Model: phase derived from counts (wait cycles, samples taken)
  bit          m_busy = 0;
  logic [1:0]  m_sw   = 2'b11;
  int          m_wait = 0;
  int          m_n    = 0;
  int          m_got  = 0;
  int          m_drop = 0;
  bit          m_ovr  = 0;
  bit          m_pend = 0;
  bit          h_v    = 0;
  logic [AW-1:0] h_d  = '0;
  bit          h_l    = 0;

  // Beats seen on m_axis in the current frame
  logic [AW-1:0] beats[$];
  int            tl_cnt;
  int            tl_idx;

  always @(negedge aclk) begin
    bit hv_old;
    bit xfer;
    if (chk_en) begin
      chk("tvalid", 64'(m_axis_tvalid), 64'(h_v));
      if (h_v) begin
        chk("tdata", 64'(m_axis_tdata), 64'(h_d));
        chk("tlast", 64'(m_axis_tlast), 64'(h_l));
      end
      chk("busy", 64'(busy), 64'(m_busy));
      chk("switch", 64'(adc_channel_switch), 64'(m_sw));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      if (m_axis_tvalid && m_axis_tready && !reset) begin
        beats.push_back(m_axis_tdata);
        if (m_axis_tlast) begin
          tl_cnt++;
          tl_idx = beats.size() - 1;
        end
      end
    end
    if (reset) begin
      m_busy = 0; m_sw = 2'b11; h_v = 0; h_d = '0; h_l = 0;
      m_ovr = 0; m_drop = 0; m_pend = 0;
    end else begin
      hv_old = h_v;
      xfer   = h_v && m_axis_tready;
      if (xfer) h_v = 0;
      if (!m_busy) begin
        if (trigger && cfg_samples != 0) begin
          m_busy = 1; m_sw = cfg_mode; m_n = int'(cfg_samples);
          m_wait = int'(cfg_delay) + 1; m_got = 0;
          m_drop = 0; m_ovr = 0; m_pend = 0;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (m_got < m_n) begin
        if (s_axis_tvalid) begin
          m_got++;
          if (!h_v) begin
            h_v = 1; h_d = s_axis_tdata; h_l = (m_got == m_n);
          end else begin
            m_ovr = 1;
            if (m_drop < (1 << CW) - 1) m_drop++;
            if (m_got == m_n) m_pend = 1;
          end
        end
      end else begin
        if (xfer && h_l) begin
          m_busy = 0; m_sw = 2'b11;
        end else if (m_pend && !hv_old) begin
          h_v = 1; h_d = '0; h_l = 1; m_pend = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic frame(input int id, input logic [1:0] mode,
                       input int dly, input int ns,
                       input int base, input int ncyc);
    beats.delete();
    tl_cnt = 0;
    tl_idx = -1;
    for (int t = 0; t < ncyc; t++) begin
      if (id == 1 && t == 0) chk("t1_sw_pre", 64'(adc_channel_switch), 64'd3);
      if (id == 1 && t == 1) begin
        chk("t1_sw_post", 64'(adc_channel_switch), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
      end
      if (id == 5 && t == 8) chk("t5_sw_kept", 64'(adc_channel_switch), 64'd1);
      if (id == 6 && t == 6) chk("t6_ovr_pre", 64'(overrun), 64'd1);
      if (id == 6 && t == 7) begin
        chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_sw", 64'(adc_channel_switch), 64'd3);
        chk("t6_rst_ovr", 64'(overrun), 64'd0);
      end
      if (t == 0) begin
        cfg_mode = mode; cfg_delay = DW'(dly); cfg_samples = CW'(ns);
      end
      if (id == 5 && t == 1) begin
        cfg_mode = 2'b10; cfg_delay = '0; cfg_samples = CW'(3);
      end
      trigger       = (t == 0) || (id == 5 && (t == 2 || t == 7));
      s_axis_tvalid = !(id == 3 && t == 8);
      m_axis_tready = !((id == 3 && t >= 8 && t <= 10) ||
                        (id == 4 && (t == 5 || t == 6)) ||
                        (id == 6 && t == 4));
      reset         = (id == 6 && t == 6);
      s_axis_tdata  = AW'(base + t);
      step();
    end
    trigger = 1'b0;
    reset = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic post(input string nm, input int cnt, input int first,
                      input int last, input int drops, input int ovr);
    logic [63:0] f;
    logic [63:0] l;
    f = '1;
    l = '1;
    if (beats.size() > 0) begin
      f = 64'(beats[0]);
      l = 64'(beats[beats.size()-1]);
    end
    chk({nm, "_len"}, 64'(beats.size()), 64'(cnt));
    chk({nm, "_first"}, f, 64'(first));
    chk({nm, "_last"}, l, 64'(last));
    chk({nm, "_tlast_cnt"}, 64'(tl_cnt), 64'd1);
    chk({nm, "_tlast_pos"}, 64'(tl_idx), 64'(cnt - 1));
    chk({nm, "_drops"}, 64'(drop_count), 64'(drops));
    chk({nm, "_ovr"}, 64'(overrun), 64'(ovr));
    chk({nm, "_idle"}, 64'(busy), 64'd0);
    chk({nm, "_sw_off"}, 64'(adc_channel_switch), 64'd3);
  endtask

  initial begin
    reset = 1'b1; trigger = 1'b0; cfg_mode = 2'b00; cfg_delay = '0;
    cfg_samples = '0; s_axis_tdata = '0; s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    step(); step(); step();
    reset = 1'b0;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sw", 64'(adc_channel_switch), 64'd3);
    chk("rst_ovr", 64'(overrun), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    step();
    chk_en = 1'b1;

    frame(1, 2'b01, 3, 8, 100, 16);
    post("basic", 8, 105, 112, 0, 0);

    frame(2, 2'b10, 0, 1, 200, 6);
    post("one", 1, 202, 202, 0, 0);

    frame(3, 2'b00, 0, 16, 300, 24);
    post("bp", 14, 302, 318, 2, 1);

    frame(4, 2'b01, 0, 4, 400, 14);
    post("lastdrop", 4, 402, 0, 1, 1);

    frame(5, 2'b01, 3, 8, 500, 18);
    post("ign", 8, 505, 512, 0, 0);

    cfg_samples = '0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("zero_trig_busy", 64'(busy), 64'd0);
    step();
    chk("zero_trig_busy2", 64'(busy), 64'd0);

    frame(6, 2'b10, 0, 10, 600, 9);
    frame(7, 2'b10, 0, 10, 700, 16);
    post("clean", 10, 702, 711, 0, 0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
